// File: rtl/apb_master_rmw_ctrl.sv
// APB master sequencer feeding the byte-masking stage.
// Partial-strobe writes run as APB read, hold read data, then APB write.
module apb_master_rmw_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    output logic [STRB_WIDTH-1:0] pstrb_byte_mask,
    output logic [DATA_WIDTH-1:0] apb_write_data,
    output logic [DATA_WIDTH-1:0] rmw_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_ACCESS,
        WR_SETUP,
        WR_ACCESS,
        RSP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;

    // Next-state, captured command/response data and next bus outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;
        rdata_d       = rdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_inc       = cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    strb_d  = cmd_strb;
                    if (!cmd_write) begin
                        state_d = RD_SETUP;
                    end else if (&cmd_strb) begin
                        state_d = WR_SETUP;
                    end else if (|cmd_strb) begin
                        state_d = RD_SETUP;
                    end else begin
                        // Empty strobe: nothing to do on the bus
                        state_d       = RSP;
                        rsp_error_d   = 1'b0;
                        rsp_timeout_d = 1'b0;
                    end
                end
            end
            RD_SETUP: begin
                cnt_d   = '0;
                state_d = RD_ACCESS;
            end
            RD_ACCESS: begin
                if (PREADY) begin
                    rdata_d     = PRDATA;
                    rsp_rdata_d = PRDATA;
                    if (PSLVERR || !write_q) begin
                        state_d       = RSP;
                        rsp_error_d   = PSLVERR;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d = WR_SETUP;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                        state_d       = RSP;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            WR_SETUP: begin
                cnt_d   = '0;
                state_d = WR_ACCESS;
            end
            WR_ACCESS: begin
                if (PREADY) begin
                    state_d       = RSP;
                    rsp_error_d   = PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                        state_d       = RSP;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave a flop
        psel_d      = (state_d == RD_SETUP) || (state_d == RD_ACCESS) ||
                      (state_d == WR_SETUP) || (state_d == WR_ACCESS);
        penable_d   = (state_d == RD_ACCESS) || (state_d == WR_ACCESS);
        pwrite_d    = (state_d == WR_SETUP) || (state_d == WR_ACCESS);
        pstrb_d     = pwrite_d ? '1 : '0;
        rsp_valid_d = (state_d == RSP);
        cmd_ready_d = (state_d == IDLE);
    end

    // FSM state and registered outputs with synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            strb_q        <= '0;
            rdata_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pstrb_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            strb_q        <= strb_d;
            rdata_q       <= rdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_valid_q   <= rsp_valid_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pstrb_q       <= pstrb_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_error       = rsp_error_q;
    assign rsp_timeout     = rsp_timeout_q;
    assign PSEL            = psel_q;
    assign PENABLE         = penable_q;
    assign PWRITE          = pwrite_q;
    assign PADDR           = addr_q;
    assign PSTRB           = pstrb_q;
    assign pstrb_byte_mask = strb_q;
    assign apb_write_data  = wdata_q;
    assign rmw_rdata       = rdata_q;

endmodule
